// File: rtl/interleaver_sweep_gen_pkg.sv
// Shared types and size derivations for the interleaver sweep generator.
// All widths are derived from p (neurons), fo (fan-out) and z (lanes).
package interleaver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    function automatic int calcLpz(input int p, input int z);
        return (p == z) ? 1 : $clog2(p / z);
    endfunction

    function automatic int calcNcyc(input int p, input int fo, input int z);
        return (p * fo) / z;
    endfunction

    function automatic int calcCw(input int p, input int fo, input int z);
        int n;
        n = calcNcyc(p, fo, z);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int calcAw(input int p);
        return (p <= 2) ? 1 : $clog2(p);
    endfunction

endpackage

// File: rtl/interleaver_sweep_gen_if.sv
// Load, control and output-stream signals of the interleaver sweep generator.
// The slave modport is the generator itself; the master side drives it.
interface interleaver_sweep_gen_if #(
    parameter int p  = 32,
    parameter int fo = 2,
    parameter int z  = 8
);
    import interleaver_pkg::*;

    localparam int LPZ = calcLpz(p, z);
    localparam int CW  = calcCw(p, fo, z);
    localparam int AW  = calcAw(p);

    logic                   ld_valid;
    logic [LPZ-1:0]         ld_data;
    logic                   ld_ready;
    logic                   start;
    logic                   perm_en;
    logic                   out_valid;
    logic                   out_ready;
    logic [CW-1:0]          out_cycle;
    logic [z-1:0][AW-1:0]   memory_index;
    logic                   loaded;
    logic                   busy;
    logic                   done;

    modport slave (
        input  ld_valid, ld_data, start, perm_en, out_ready,
        output ld_ready, out_valid, out_cycle, memory_index, loaded, busy, done
    );

    modport master (
        output ld_valid, ld_data, start, perm_en, out_ready,
        input  ld_ready, out_valid, out_cycle, memory_index, loaded, busy, done
    );

endinterface

// File: rtl/interleaver_sweep_gen_lane_map.sv
// One lane of the address mapping: rotates the lane's sweepstart chunk by the
// cycle's position within its sweep, or passes a linear address through.
module interleaver_lane_map
    import interleaver_pkg::*;
#(
    parameter int p    = 32,
    parameter int fo   = 2,
    parameter int z    = 8,
    parameter int LANE = 0
) (
    input  logic [calcCw(p, fo, z)-1:0] cycle_i,
    input  logic [calcLpz(p, z)-1:0]    ss_i,
    input  logic                        permEn_i,
    output logic [calcAw(p)-1:0]        memIdx_o
);
    localparam int LPZ = calcLpz(p, z);
    localparam int AW  = calcAw(p);

    // Rotation wraps naturally modulo p/z in LPZ bits.
    logic [LPZ-1:0] rot;
    assign rot = ss_i + cycle_i[LPZ-1:0];

    always_comb begin
        memIdx_o = '0;
        if (p == z) begin
            memIdx_o = AW'(LANE);
        end else if (permEn_i) begin
            memIdx_o = AW'(int'(rot) * z + LANE);
        end else begin
            memIdx_o = AW'(int'(cycle_i) * z + LANE);
        end
    end

endmodule

// File: rtl/interleaver_sweep_gen.sv
// Loads a sweepstart table in chunks, then streams one junction of per-lane
// activation-memory addresses with a valid/ready handshake.
module interleaver_sweep_gen
    import interleaver_pkg::*;
#(
    parameter int p  = 32,
    parameter int fo = 2,
    parameter int z  = 8
) (
    input logic                    clk,
    input logic                    reset,
    interleaver_sweep_gen_if.slave bus
);
    localparam int LPZ  = calcLpz(p, z);
    localparam int NCH  = fo * z;
    localparam int NCYC = calcNcyc(p, fo, z);
    localparam int CW   = calcCw(p, fo, z);
    localparam int AW   = calcAw(p);
    localparam int CNTW = (NCH <= 2) ? 1 : $clog2(NCH);

    state_e               state_q;
    logic [CNTW-1:0]      ldCnt_q;
    logic [LPZ-1:0]       ss_q [NCH];
    logic                 loaded_q;
    logic                 outValid_q;
    logic                 done_q;
    logic                 busy_q;
    logic                 permEn_q;
    logic                 permEn_d;
    logic [CW-1:0]        outCycle_q;
    logic [CW-1:0]        outCycle_d;
    logic [z-1:0][AW-1:0] memIdx_q;
    logic [z-1:0][AW-1:0] laneIdx;
    logic [LPZ-1:0]       ssSel [z];

    logic            startAcc;
    logic            ldAcc;
    logic            hs;
    logic            lastHs;
    logic            advance;
    logic            lastChunk;
    logic [CNTW-1:0] ldIdx;

    // Start takes priority over a chunk offered in the same IDLE cycle.
    assign startAcc  = (state_q == IDLE) && bus.start && loaded_q;
    assign ldAcc     = bus.ld_valid && (state_q != RUN) && !startAcc;
    assign ldIdx     = (state_q == LOAD) ? ldCnt_q : '0;
    assign lastChunk = (ldIdx == CNTW'(NCH - 1));
    assign hs        = outValid_q && bus.out_ready;
    assign lastHs    = hs && (outCycle_q == CW'(NCYC - 1));
    assign advance   = startAcc || (hs && !lastHs);
    assign permEn_d  = startAcc ? bus.perm_en : permEn_q;

    always_comb begin
        outCycle_d = outCycle_q;
        if (startAcc) begin
            outCycle_d = '0;
        end else if (hs && !lastHs) begin
            outCycle_d = outCycle_q + 1'b1;
        end
    end

    // Addresses are computed for the upcoming cycle so they can be registered.
    for (genvar j = 0; j < z; j++) begin : gLane
        assign ssSel[j] = ss_q[CNTW'((int'(outCycle_d) >> LPZ) * z + j)];

        interleaver_lane_map #(
            .p   (p),
            .fo  (fo),
            .z   (z),
            .LANE(j)
        ) uMap (
            .cycle_i (outCycle_d),
            .ss_i    (ssSel[j]),
            .permEn_i(permEn_d),
            .memIdx_o(laneIdx[j])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ldCnt_q    <= '0;
            loaded_q   <= 1'b0;
            outValid_q <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            permEn_q   <= 1'b0;
            outCycle_q <= '0;
            memIdx_q   <= '0;
            for (int k = 0; k < NCH; k++) begin
                ss_q[k] <= '0;
            end
        end else begin
            done_q     <= lastHs;
            outCycle_q <= outCycle_d;
            permEn_q   <= permEn_d;
            if (advance) begin
                memIdx_q <= laneIdx;
            end
            if (startAcc) begin
                state_q    <= RUN;
                outValid_q <= 1'b1;
                busy_q     <= 1'b1;
            end else if (ldAcc) begin
                ss_q[ldIdx] <= bus.ld_data;
                if (lastChunk) begin
                    state_q  <= IDLE;
                    ldCnt_q  <= '0;
                    loaded_q <= 1'b1;
                    busy_q   <= 1'b0;
                end else begin
                    state_q  <= LOAD;
                    ldCnt_q  <= ldIdx + 1'b1;
                    loaded_q <= 1'b0;
                    busy_q   <= 1'b1;
                end
            end else if (lastHs) begin
                state_q    <= IDLE;
                outValid_q <= 1'b0;
                busy_q     <= 1'b0;
            end
        end
    end

    assign bus.ld_ready     = (state_q != RUN);
    assign bus.out_valid    = outValid_q;
    assign bus.out_cycle    = outCycle_q;
    assign bus.memory_index = memIdx_q;
    assign bus.loaded       = loaded_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_interleaver_sweep_gen.sv
// Self-checking bench: table vectors, corner-case sequences and randomized
// junctions against a reference model, for p=8/fo=2/z=4 and p=z=4/fo=1.
module tb_interleaver_sweep_gen;
    import interleaver_pkg::*;

    localparam int P  = 8;
    localparam int FO = 2;
    localparam int Z  = 4;
    localparam int PZ = P / Z;

    typedef logic [3:0][2:0] laneVec_t;
    typedef logic [3:0][3:0][2:0] junction_t;

    typedef struct packed {
        logic      perm;
        logic [7:0] ss;
        junction_t expJ;
    } vector_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    interleaver_sweep_gen_if #(.p(8), .fo(2), .z(4)) busA ();
    interleaver_sweep_gen_if #(.p(4), .fo(1), .z(4)) busB ();

    interleaver_sweep_gen #(.p(8), .fo(2), .z(4)) dutA (
        .clk  (clk),
        .reset(reset),
        .bus  (busA)
    );

    interleaver_sweep_gen #(.p(4), .fo(1), .z(4)) dutB (
        .clk  (clk),
        .reset(reset),
        .bus  (busB)
    );

    int nCompared = 0;
    int nMismatched = 0;
    vector_t vecs [4];

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    function automatic laneVec_t mk4(input int a, input int b, input int c, input int d);
        laneVec_t v;
        v[0] = 3'(a);
        v[1] = 3'(b);
        v[2] = 3'(c);
        v[3] = 3'(d);
        return v;
    endfunction

    // Reference: each sweep of p/z cycles reuses z chunks, lane j's base row
    // advances by one row per cycle (wrapping within the p/z rows).
    function automatic junction_t modelJunction(input logic [7:0] ss, input logic perm);
        junction_t res;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < Z; j++) begin
                int sweep;
                int row;
                int v;
                sweep = c / PZ;
                row   = c % PZ;
                if (perm) begin
                    v = ((int'(ss[sweep * Z + j]) + row) % PZ) * Z + j;
                end else begin
                    v = (c * Z + j) % P;
                end
                res[c][j] = 3'(v);
            end
        end
        return res;
    endfunction

    // Loads eight 1-bit chunks into DUT A; optionally raises start mid-load.
    task automatic applyStimulus(input logic [7:0] ss, input int startAt);
        for (int k = 0; k < 8; k++) begin
            busA.ld_valid = 1'b1;
            busA.ld_data  = ss[k];
            busA.start    = (k == startAt);
            checkOutput("ld_ready in load", 64'(busA.ld_ready), 64'd1);
            if (k > 0) begin
                checkOutput("loaded during load", 64'(busA.loaded), 64'd0);
                checkOutput("busy during load", 64'(busA.busy), 64'd1);
            end
            if (startAt >= 0 && k == startAt + 1) begin
                checkOutput("start in LOAD ignored", 64'(busA.out_valid), 64'd0);
            end
            @(negedge clk);
        end
        busA.ld_valid = 1'b0;
        busA.start    = 1'b0;
        checkOutput("loaded after load", 64'(busA.loaded), 64'd1);
        checkOutput("busy after load", 64'(busA.busy), 64'd0);
        checkOutput("out_valid after load", 64'(busA.out_valid), 64'd0);
    endtask

    // Runs one junction on DUT A and compares every cycle against expJ.
    task automatic runJunction(input logic perm, input junction_t expJ, input int stallAt,
                               input int stallLen, input logic pokeLoad);
        busA.start     = 1'b1;
        busA.perm_en   = perm;
        busA.out_ready = 1'b1;
        busA.ld_valid  = pokeLoad;
        busA.ld_data   = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == stallAt) begin
                for (int k = 0; k < stallLen; k++) begin
                    busA.out_ready = 1'b0;
                    checkOutput("stall out_valid", 64'(busA.out_valid), 64'd1);
                    checkOutput("stall out_cycle", 64'(busA.out_cycle), 64'(c));
                    checkOutput("stall memory_index", 64'(busA.memory_index), 64'(expJ[c]));
                    @(negedge clk);
                end
                busA.out_ready = 1'b1;
            end
            checkOutput("out_valid", 64'(busA.out_valid), 64'd1);
            checkOutput("out_cycle", 64'(busA.out_cycle), 64'(c));
            checkOutput("memory_index", 64'(busA.memory_index), 64'(expJ[c]));
            checkOutput("done in run", 64'(busA.done), 64'd0);
            checkOutput("ld_ready in run", 64'(busA.ld_ready), 64'd0);
            if (c == 3) begin
                busA.ld_valid = 1'b0;
            end
            @(negedge clk);
        end
        checkOutput("out_valid after last", 64'(busA.out_valid), 64'd0);
        checkOutput("done pulse", 64'(busA.done), 64'd1);
        checkOutput("loaded kept", 64'(busA.loaded), 64'd1);
        checkOutput("busy after run", 64'(busA.busy), 64'd0);
        @(negedge clk);
        checkOutput("done single cycle", 64'(busA.done), 64'd0);
    endtask

    initial begin
        vecs[0].perm = 1'b1;
        vecs[0].ss   = 8'b0100_1101;
        vecs[0].expJ = {mk4(4, 5, 2, 7), mk4(0, 1, 6, 3), mk4(0, 5, 2, 3), mk4(4, 1, 6, 7)};
        vecs[1].perm = 1'b0;
        vecs[1].ss   = 8'b0100_1101;
        vecs[1].expJ = {mk4(4, 5, 6, 7), mk4(0, 1, 2, 3), mk4(4, 5, 6, 7), mk4(0, 1, 2, 3)};
        vecs[2].perm = 1'b1;
        vecs[2].ss   = 8'h00;
        vecs[2].expJ = {mk4(4, 5, 6, 7), mk4(0, 1, 2, 3), mk4(4, 5, 6, 7), mk4(0, 1, 2, 3)};
        vecs[3].perm = 1'b1;
        vecs[3].ss   = 8'hFF;
        vecs[3].expJ = {mk4(0, 1, 2, 3), mk4(4, 5, 6, 7), mk4(0, 1, 2, 3), mk4(4, 5, 6, 7)};

        reset = 1'b1;
        busA.ld_valid = 1'b0; busA.ld_data = '0; busA.start = 1'b0;
        busA.perm_en = 1'b0; busA.out_ready = 1'b1;
        busB.ld_valid = 1'b0; busB.ld_data = '0; busB.start = 1'b0;
        busB.perm_en = 1'b0; busB.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        checkOutput("reset out_valid", 64'(busA.out_valid), 64'd0);
        checkOutput("reset loaded", 64'(busA.loaded), 64'd0);
        checkOutput("reset busy", 64'(busA.busy), 64'd0);
        checkOutput("reset done", 64'(busA.done), 64'd0);
        checkOutput("reset ld_ready", 64'(busA.ld_ready), 64'd1);
        checkOutput("reset out_cycle", 64'(busA.out_cycle), 64'd0);
        checkOutput("reset memory_index", 64'(busA.memory_index), 64'd0);
        checkOutput("reset B loaded", 64'(busB.loaded), 64'd0);

        busA.start = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("start unloaded out_valid", 64'(busA.out_valid), 64'd0);
        checkOutput("start unloaded busy", 64'(busA.busy), 64'd0);
        busA.start = 1'b0;

        for (int v = 0; v < 4; v++) begin
            applyStimulus(vecs[v].ss, -1);
            runJunction(vecs[v].perm, vecs[v].expJ, 4, 0, 1'b0);
        end

        $display("[TB] stall at cycle 2 and start during load");
        applyStimulus(vecs[0].ss, 3);
        runJunction(1'b1, vecs[0].expJ, 2, 3, 1'b0);

        $display("[TB] chunks offered at start and during run are not taken");
        runJunction(1'b1, vecs[0].expJ, 4, 0, 1'b1);
        runJunction(1'b1, vecs[0].expJ, 1, 2, 1'b0);

        $display("[TB] reset during run");
        busA.start = 1'b1; busA.perm_en = 1'b1; busA.out_ready = 1'b1;
        @(negedge clk);
        busA.start = 1'b0;
        @(negedge clk);
        checkOutput("pre-reset out_cycle", 64'(busA.out_cycle), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort out_valid", 64'(busA.out_valid), 64'd0);
        checkOutput("abort loaded", 64'(busA.loaded), 64'd0);
        checkOutput("abort done", 64'(busA.done), 64'd0);
        checkOutput("abort busy", 64'(busA.busy), 64'd0);
        checkOutput("abort memory_index", 64'(busA.memory_index), 64'd0);
        @(negedge clk);
        checkOutput("abort no done later", 64'(busA.done), 64'd0);
        applyStimulus(vecs[0].ss, -1);
        runJunction(1'b1, vecs[0].expJ, 4, 0, 1'b0);

        $display("[TB] randomized junctions");
        for (int it = 0; it < 20; it++) begin
            logic [7:0] ss;
            logic       perm;
            ss   = 8'($urandom);
            perm = 1'($urandom);
            applyStimulus(ss, -1);
            runJunction(perm, modelJunction(ss, perm), int'($urandom_range(0, 4)),
                        int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] p=z=4, fo=1");
        for (int k = 0; k < 4; k++) begin
            busB.ld_valid = 1'b1;
            busB.ld_data  = 1'($urandom);
            @(negedge clk);
        end
        busB.ld_valid = 1'b0;
        checkOutput("B loaded", 64'(busB.loaded), 64'd1);
        busB.start = 1'b1; busB.perm_en = 1'b1; busB.out_ready = 1'b1;
        @(negedge clk);
        busB.start = 1'b0;
        checkOutput("B out_valid", 64'(busB.out_valid), 64'd1);
        checkOutput("B out_cycle", 64'(busB.out_cycle), 64'd0);
        checkOutput("B memory_index", 64'(busB.memory_index), 64'({2'd3, 2'd2, 2'd1, 2'd0}));
        @(negedge clk);
        checkOutput("B out_valid after", 64'(busB.out_valid), 64'd0);
        checkOutput("B done", 64'(busB.done), 64'd1);
        @(negedge clk);
        checkOutput("B done single cycle", 64'(busB.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/interleaver_sweep_gen.md
INTERLEAVER_SWEEP_GEN -- requirements
Module: interleaver_sweep_gen

Interface
REQ-001 Parameter p, default 32: number of left-hand neurons; power of 2; p >= z.
REQ-002 Parameter fo, default 2: fan-out; power of 2; fo >= 1.
REQ-003 Parameter z, default 8: lanes (parallel accesses) per cycle; power of 2.
REQ-004 Derived constants: LPZ = (p==z) ? 1 : clog2(p/z); NCH = fo*z (sweepstart chunks); NCYC = p*fo/z (cycles per junction); CW = max(1, clog2(NCYC)).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ld_valid  input  1  a sweepstart chunk is offered.
REQ-008 ld_data  input  LPZ  chunk value, range 0..p/z-1.
REQ-009 ld_ready  output  1  the block accepts chunks this cycle.
REQ-010 start  input  1  request to begin one junction pass.
REQ-011 perm_en  input  1  1 = interleave, 0 = identity; sampled when start is accepted.
REQ-012 out_valid  output  1  out_cycle and memory_index are valid.
REQ-013 out_ready  input  1  consumer accepts the current output.
REQ-014 out_cycle  output  CW  eff_cycle_index of the current output.
REQ-015 memory_index  output  z x clog2(p)  activation-memory address for each lane.
REQ-016 loaded  output  1  a complete sweepstart table is held.
REQ-017 busy  output  1  high in LOAD or RUN.
REQ-018 done  output  1  one-cycle pulse after the last output is accepted.

Function
REQ-019 States: IDLE, LOAD, RUN.
- IDLE -> LOAD on ld_valid.
- IDLE -> RUN on start && loaded.
- LOAD -> IDLE after chunk NCH-1 is accepted.
- RUN -> IDLE on handshake of cycle NCYC-1.
REQ-020 Loading:
- ld_ready = 1 in IDLE and LOAD, 0 in RUN.
- A chunk is accepted when ld_valid && ld_ready; the k-th accepted chunk of a load is stored as ss[k].
- k runs 0..NCH-1.
REQ-021 A chunk accepted in IDLE clears loaded and becomes ss[0] of a new load; loaded sets on the cycle after chunk NCH-1 is accepted.
REQ-022 Simultaneous start && loaded && ld_valid in IDLE: start wins, the chunk is not accepted, and the state moves to RUN.
REQ-023 start is ignored when loaded = 0, in LOAD, and in RUN.
REQ-024 When start is accepted at edge N, out_valid = 1 with out_cycle = 0 from edge N (one cycle later); all outputs are registered.
REQ-025 Handshake:
- On out_valid && out_ready, out_cycle increments on the next edge.
- While out_ready = 0, out_cycle and memory_index hold stable.
- There are no gaps between cycles while out_ready = 1.
REQ-026 After the handshake of out_cycle = NCYC-1:
- out_valid = 0 on the next edge;
- done = 1 for exactly that one cycle;
- the state returns to IDLE and loaded stays 1.
REQ-027 Mapping, with c = out_cycle, s = c >> LPZ, r = c mod (p/z), lane j:
- perm_en = 1: memory_index[j] = ((ss[s*z+j] + r) mod (p/z))*z + j.
- perm_en = 0: memory_index[j] = (c*z + j) mod p.
REQ-028 The mod p/z wraps naturally in LPZ bits. When p == z: memory_index[j] = j for every c, and ss content is irrelevant (chunks still counted).
REQ-029 When fo == 1: s = 0 always.

Reset
REQ-030 Reset values: state IDLE, load counter 0, out_cycle 0, out_valid 0, done 0, loaded 0, busy 0, memory_index all 0; ss is cleared to 0.
REQ-031 Reset asserted mid-LOAD or mid-RUN aborts the operation and applies REQ-030 on that edge; done is not pulsed.

Structure
REQ-032 Package interleaver_pkg shall hold the state enum typedef and the LPZ/NCYC/CW derivation functions.
REQ-033 The table ss shall be a 1-D flop array of NCH entries, LPZ bits each (not a parameter constant).
REQ-034 One combinational sub-module, interleaver_lane_map, shall compute one lane of REQ-027 and be instantiated z times.

Verification (p=8, fo=2, z=4 unless stated)
REQ-035 Load ss = 1,0,1,1,0,0,1,0, then start with perm_en=1 and out_ready=1 -> cycles 0..3 give {4,1,6,7}, {0,5,2,3}, {0,1,6,3}, {4,5,2,7}; done pulses one cycle after cycle 3.
REQ-036 Same load, start with perm_en=0 -> {0,1,2,3}, {4,5,6,7}, {0,1,2,3}, {4,5,6,7}.
REQ-037 Deassert out_ready for 3 cycles at out_cycle=2 -> outputs hold {0,1,6,3}; the next cycle is 3 with no skip or repeat.
REQ-038 start with loaded=0, and start during LOAD -> ignored, out_valid stays 0; ld_valid in RUN -> ld_ready=0 and ss unchanged.
REQ-039 Reset at out_cycle=1 -> next cycle out_valid=0, loaded=0, no done; a reload plus start reproduces REQ-035.
REQ-040 p=z=4, fo=1 -> four loaded chunks, then one output cycle {0,1,2,3}.
